fetch_unit_prefetch: RTL
========================

Name: fetch_unit_prefetch

Overview:
Parametrised next-generation instruction fetch stage with a small prefetch queue between instruction memory and decode. Issues one fetch per cycle while queue space exists and absorbs decode back-pressure through a valid/ready handshake. Handles redirects (branch/jump/JR) from decode by flushing queued and in-flight instructions. Sits between the PC/redirect logic of decode and a synchronous instruction memory with 1-cycle read latency.

Parameters:
NB_ADDR, 32, PC/address width
NB_INSTR, 32, instruction width
FIFO_DEPTH, 4, prefetch queue entries (power of 2, >=2)
LOG2_DEPTH, clogb2(FIFO_DEPTH-1), queue pointer width
RESET_PC, 0, fetch address after reset
NOP_INSTR, 32'h0000_0000, value driven on o_ir when not valid

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  global step enable; 0 freezes all state
o_imem_addr  out  NB_ADDR  fetch address, word aligned
o_imem_en  out  1  memory read enable; memory holds o_data when low
i_imem_data  in  NB_INSTR  read data, valid 1 cycle after o_imem_en
i_redirect  in  1  taken branch/jump from decode
i_redirect_pc  in  NB_ADDR  redirect target
o_ir  out  NB_INSTR  queue head instruction, NOP_INSTR when o_valid=0
o_pc  out  NB_ADDR  address of o_ir plus 4
o_valid  out  1  queue head valid
i_ready  in  1  decode accepts head
o_misaligned  out  1  1-cycle pulse: redirect target low 2 bits nonzero

Behaviour:
- Reset: fetch_pc=RESET_PC, queue empty, in-flight flag cleared; o_valid=0, o_ir=NOP_INSTR, o_pc=0, o_imem_en=0, o_misaligned=0.
- i_valid=0: no register changes, o_imem_en=0; outputs hold.
- Issue: o_imem_en=1 when i_valid & !i_redirect & (count + inflight) < FIFO_DEPTH; o_imem_addr=fetch_pc; fetch_pc += 4 on issue. inflight set on issue, cleared on return.
- Return: cycle after issue, {fetch address+4, i_imem_data} pushed into queue; throttling guarantees no overflow.
- Pop: o_valid & i_ready & i_valid. Push and pop in the same cycle keep count unchanged, at any fill level.
- Queue head is registered storage, no bypass: memory return at cycle t -> o_valid at t+1.
- Redirect (i_redirect & i_valid), highest priority: queue cleared, concurrent pop ignored, concurrent return discarded, in-flight response of that cycle killed; fetch_pc <= {i_redirect_pc[NB_ADDR-1:2],2'b00}; o_misaligned pulses next cycle when i_redirect_pc[1:0]!=0. First target fetch issues at t+1, o_valid at t+3.
- Reset mid-operation: all state cleared on the next edge; the pending return is dropped.
- fetch_pc wraps modulo 2^NB_ADDR without error.

Decomposition:
- Shared package: NOP_INSTR, PC_INCR=4, clogb2 function.
- Sub-module fetch_fifo: synchronous FIFO, width NB_ADDR+NB_INSTR, depth FIFO_DEPTH, with push/pop/flush and count output. Issue control, kill logic and fetch_pc remain in the top level.

Test Plan:
- Reset with i_ready=1 -> o_imem_en at first cycle after reset with addr 0; o_valid from cycle 2; o_pc=4,8,12,... one per cycle, no bubbles.
- i_ready=0 for 10 cycles -> exactly 4 entries queued, o_imem_en stays low, head unchanged; on release, o_pc continues 4,8,12,16,20 with no loss or duplication.
- Redirect to 0x40 with full queue -> o_valid=0 for 2 cycles, then o_pc=0x44 with the 0x40 instruction; old entries never appear.
- Redirect in the same cycle as a memory return and i_ready=1 -> returned instruction discarded, pop ignored, next valid o_pc=target+4.
- Redirect to 0x42 -> fetch at 0x40, o_misaligned single pulse.
- i_valid=0 for 5 cycles mid-stream -> no address advance, outputs frozen; stream resumes exactly in order.

Source files
------------

// File: rtl/fetch_unit_prefetch_pkg.sv
// rtl/fetch_unit_prefetch_pkg.sv - shared constants and helpers for the prefetching fetch stage
package fetch_unit_prefetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_INCR   = 4;

    // Number of bits needed to hold value (at least 1).
    function automatic int clogb2(input int value);
        int n;
        n = 1;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_unit_prefetch_if.sv
// rtl/fetch_unit_prefetch_if.sv - memory, redirect and decode handshake bundle of the fetch stage
interface fetch_unit_prefetch_if #(
    parameter int NB_ADDR  = 32,
    parameter int NB_INSTR = 32
);
    logic [NB_ADDR-1:0]  o_imem_addr;
    logic                o_imem_en;
    logic [NB_INSTR-1:0] i_imem_data;
    logic                i_redirect;
    logic [NB_ADDR-1:0]  i_redirect_pc;
    logic [NB_INSTR-1:0] o_ir;
    logic [NB_ADDR-1:0]  o_pc;
    logic                o_valid;
    logic                i_ready;
    logic                o_misaligned;

    modport master (
        output o_imem_addr, o_imem_en, o_ir, o_pc, o_valid, o_misaligned,
        input  i_imem_data, i_redirect, i_redirect_pc, i_ready
    );

    modport slave (
        input  o_imem_addr, o_imem_en, o_ir, o_pc, o_valid, o_misaligned,
        output i_imem_data, i_redirect, i_redirect_pc, i_ready
    );
endinterface

// File: rtl/fetch_unit_prefetch_fetch_fifo.sv
// rtl/fetch_unit_prefetch_fetch_fifo.sv - synchronous prefetch queue with push/pop/flush and fill count
module fetch_fifo
    import fetch_unit_prefetch_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 4,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [WIDTH-1:0]      o_head,
    output logic                  o_empty,
    output logic [LOG2_DEPTH:0]   o_count
);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [LOG2_DEPTH:0]   count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push) begin
                wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
            end
            if (i_pop) begin
                rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
            end
            case ({i_push, i_pop})
                2'b10:   count <= count + (LOG2_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG2_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_push && !i_flush && !i_reset) begin
            mem[wr_ptr] <= i_data;
        end
    end

    assign o_head  = mem[rd_ptr];
    assign o_empty = (count == '0);
    assign o_count = count;

endmodule

// File: rtl/fetch_unit_prefetch.sv
// rtl/fetch_unit_prefetch.sv - instruction fetch stage with prefetch queue, throttled issue and redirect flush
module fetch_unit_prefetch
    import fetch_unit_prefetch_pkg::*;
#(
    parameter int                  NB_ADDR    = 32,
    parameter int                  NB_INSTR   = 32,
    parameter int                  FIFO_DEPTH = 4,
    parameter int                  LOG2_DEPTH = clogb2(FIFO_DEPTH-1),
    parameter logic [NB_ADDR-1:0]  RESET_PC   = '0,
    parameter logic [NB_INSTR-1:0] NOP_INSTR  = NB_INSTR'(fetch_unit_prefetch_pkg::NOP_INSTR)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    fetch_unit_prefetch_if.master bus
);

    localparam int                OCC_W   = LOG2_DEPTH + 2;
    localparam logic [OCC_W-1:0]  DEPTH_C = OCC_W'(FIFO_DEPTH);
    localparam logic [NB_ADDR-1:0] INCR   = NB_ADDR'(PC_INCR);

    logic [NB_ADDR-1:0]          fetch_pc;
    logic [NB_ADDR-1:0]          pend_pc;
    logic                        inflight;
    logic                        misaligned_q;

    logic                        step;
    logic                        redirect_now;
    logic                        issue;
    logic                        ret;
    logic                        pop;
    logic                        head_valid;
    logic                        fifo_empty;
    logic [LOG2_DEPTH:0]         count;
    logic [OCC_W-1:0]            occupancy;
    logic [NB_ADDR+NB_INSTR-1:0] head;

    assign step         = i_valid & ~i_reset;
    assign redirect_now = step & bus.i_redirect;
    // Occupancy counts the outstanding read so a full queue can never be overrun.
    assign occupancy    = OCC_W'(count) + OCC_W'(inflight);
    assign issue        = step & ~bus.i_redirect & (occupancy < DEPTH_C);
    assign ret          = step & ~bus.i_redirect & inflight;
    assign head_valid   = ~fifo_empty;
    assign pop          = step & ~bus.i_redirect & head_valid & bus.i_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fetch_pc     <= RESET_PC;
            pend_pc      <= '0;
            inflight     <= 1'b0;
            misaligned_q <= 1'b0;
        end else if (i_valid) begin
            if (bus.i_redirect) begin
                fetch_pc     <= {bus.i_redirect_pc[NB_ADDR-1:2], 2'b00};
                inflight     <= 1'b0;
                misaligned_q <= |bus.i_redirect_pc[1:0];
            end else begin
                misaligned_q <= 1'b0;
                inflight     <= issue;
                if (issue) begin
                    fetch_pc <= fetch_pc + INCR;
                    pend_pc  <= fetch_pc + INCR;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH      (NB_ADDR + NB_INSTR),
        .DEPTH      (FIFO_DEPTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (ret),
        .i_data  ({pend_pc, bus.i_imem_data}),
        .i_pop   (pop),
        .i_flush (redirect_now),
        .o_head  (head),
        .o_empty (fifo_empty),
        .o_count (count)
    );

    assign bus.o_imem_addr  = fetch_pc;
    assign bus.o_imem_en    = issue;
    assign bus.o_valid      = head_valid;
    assign bus.o_ir         = head_valid ? head[NB_INSTR-1:0] : NOP_INSTR;
    assign bus.o_pc         = head_valid ? head[NB_ADDR+NB_INSTR-1:NB_INSTR] : '0;
    assign bus.o_misaligned = misaligned_q;

endmodule
